// File: rtl/cpu_trace_buffer_if.sv
// Read-side handshake of the instruction trace buffer: valid/ready with the head entry.
interface cpu_trace_buffer_if #(
   parameter int DATA_W = 96
) ();
   logic              rd_valid;
   logic              rd_ready;
   logic [DATA_W-1:0] rd_data;

   modport master (output rd_valid, output rd_data, input rd_ready);
   modport slave  (input rd_valid, input rd_data, output rd_ready);
endinterface

// File: rtl/cpu_trace_buffer.sv
// 6502 instruction trace capture: snapshots core state on each decode into a DEPTH-entry FIFO.
// Define TRACE_TRIG_EN to add the ARMED state that waits for pc==trig_pc before capturing.
module cpu_trace_buffer #(
   parameter int DEPTH = 64,
   parameter int CYC_W = 32,
   parameter int PC_W  = 16
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         clock_en,
   input  logic                         decode_valid,
   input  logic [PC_W-1:0]              pc,
   input  logic [7:0]                   opcode,
   input  logic [7:0]                   a,
   input  logic [7:0]                   x,
   input  logic [7:0]                   y,
   input  logic [7:0]                   p,
   input  logic [7:0]                   sp,
   input  logic                         arm,
   input  logic                         stop,
   input  logic                         ring_mode,
   input  logic [PC_W-1:0]              trig_pc,
   cpu_trace_buffer_if.master           rd,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic [15:0]                  dropped,
   output logic                         busy,
   output logic                         done
);
   localparam int DW    = PC_W + 48 + CYC_W;
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
`ifdef TRACE_TRIG_EN
      S_ARMED   = 2'd1,
`endif
      S_CAPTURE = 2'd2,
      S_DONE    = 2'd3
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [15:0]        dropped_q, dropped_d;
   logic [CYC_W-1:0]   cyc_q, cyc_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic               ring_q, ring_d;
   logic [DW-1:0]      mem_q [DEPTH];

   logic               push, pop, drop, full;
   logic [DW-1:0]      wr_entry;

`ifndef TRACE_TRIG_EN
   logic unused_trig;
   assign unused_trig = ^trig_pc;
`endif

   assign full     = (count_q == CNT_W'(DEPTH));
   assign wr_entry = {cyc_q, pc, opcode, a, x, y, p, sp};

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      dropped_d = dropped_q;
      cyc_d     = cyc_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      ring_d    = ring_q;
      push      = 1'b0;
      pop       = 1'b0;
      drop      = 1'b0;
      if (clock_en) begin
         cyc_d = cyc_q + CYC_W'(1);
         if (arm) begin
            // arm restarts from any state and swallows a same-cycle pop or decode
`ifdef TRACE_TRIG_EN
            state_d = S_ARMED;
`else
            state_d = S_CAPTURE;
`endif
            count_d   = '0;
            dropped_d = '0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            cyc_d     = '0;
            ring_d    = ring_mode;
         end else begin
            pop = rd.rd_ready && (count_q != '0);
            case (state_q)
`ifdef TRACE_TRIG_EN
               S_ARMED: begin
                  if (stop)                                  state_d = S_DONE;
                  else if (decode_valid && (pc == trig_pc))  push = 1'b1;
               end
`endif
               S_CAPTURE: begin
                  if (stop)              state_d = S_DONE;
                  else if (decode_valid) push = 1'b1;
               end
               default: ;
            endcase
            // A full buffer with no pop either overwrites the oldest (ring) or refuses the write
            if (push && full && !pop) begin
               if (ring_q) drop = 1'b1;
               else        push = 1'b0;
            end
            case ({push, pop})
               2'b10:   if (!drop) count_d = count_q + CNT_W'(1);
               2'b01:   count_d = count_q - CNT_W'(1);
               default: ;
            endcase
            if (push)        wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop || drop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (drop && (dropped_q != 16'hFFFF)) dropped_d = dropped_q + 16'd1;
            if (push) begin
               if (!ring_q && (count_d == CNT_W'(DEPTH))) state_d = S_DONE;
               else                                        state_d = S_CAPTURE;
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= S_IDLE;
         count_q   <= '0;
         dropped_q <= '0;
         cyc_q     <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         ring_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         dropped_q <= dropped_d;
         cyc_q     <= cyc_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         ring_q    <= ring_d;
      end
   end

   // Storage is not reset; count gates visibility so stale slots never reach rd_data
   always_ff @(posedge clock) begin
      if (push) mem_q[wr_ptr_q] <= wr_entry;
   end

   assign rd.rd_valid = (count_q != '0);
   assign rd.rd_data  = rd.rd_valid ? mem_q[rd_ptr_q] : '0;
   assign count       = count_q;
   assign dropped     = dropped_q;
`ifdef TRACE_TRIG_EN
   assign busy        = (state_q == S_ARMED) || (state_q == S_CAPTURE);
`else
   assign busy        = (state_q == S_CAPTURE);
`endif
   assign done        = (state_q == S_DONE);
endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Randomized bench for cpu_trace_buffer against a queue-based reference model, plus directed scenarios.
module tb_cpu_trace_buffer;
   localparam int DEPTH = 4;
   localparam int CYC_W = 32;
   localparam int PC_W  = 16;
   localparam int DW    = PC_W + 48 + CYC_W;
   localparam int CNT_W = $clog2(DEPTH+1);
`ifdef TRACE_TRIG_EN
   localparam bit TRIG = 1'b1;
`else
   localparam bit TRIG = 1'b0;
`endif

   logic             clock = 1'b0;
   logic             reset, clock_en, decode_valid, arm, stop, ring_mode;
   logic [PC_W-1:0]  pc, trig_pc;
   logic [7:0]       opcode, a, x, y, p, sp;
   logic [CNT_W-1:0] count;
   logic [15:0]      dropped;
   logic             busy, done;

   cpu_trace_buffer_if #(.DATA_W(DW)) rd_if ();

   cpu_trace_buffer #(.DEPTH(DEPTH), .CYC_W(CYC_W), .PC_W(PC_W)) dut (
      .clock(clock), .reset(reset), .clock_en(clock_en), .decode_valid(decode_valid),
      .pc(pc), .opcode(opcode), .a(a), .x(x), .y(y), .p(p), .sp(sp),
      .arm(arm), .stop(stop), .ring_mode(ring_mode), .trig_pc(trig_pc),
      .rd(rd_if.master), .count(count), .dropped(dropped), .busy(busy), .done(done)
   );

   always #5 clock = ~clock;

   int n_chk = 0;
   int n_err = 0;

   // reference model: session state (0 idle, 1 armed, 2 capture, 3 done), queue of entries
   logic [DW-1:0]    mq [$];
   int               mst = 0;
   logic [CYC_W-1:0] mcyc = '0;
   int               mdrop = 0;
   bit               mring = 1'b0;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_step();
      if (reset) begin
         mq.delete(); mst = 0; mcyc = '0; mdrop = 0; mring = 1'b0;
      end else if (clock_en) begin
         if (arm) begin
            mq.delete(); mdrop = 0; mring = ring_mode; mst = TRIG ? 1 : 2; mcyc = '0;
         end else begin
            if (rd_if.rd_ready && mq.size() > 0) void'(mq.pop_front());
            if ((mst == 1 || mst == 2) && stop) mst = 3;
            else if (decode_valid && (mst == 2 || (mst == 1 && pc == trig_pc))) begin
               mq.push_back({mcyc, pc, opcode, a, x, y, p, sp});
               mst = 2;
               if (mq.size() > DEPTH) begin
                  void'(mq.pop_front());
                  if (mdrop < 65535) mdrop++;
               end
               if (!mring && mq.size() == DEPTH) mst = 3;
            end
            mcyc = mcyc + 1;
         end
      end
   endtask

   // compare outputs mid-cycle, advance the model with the applied inputs, then step one clock
   task automatic tick();
      logic [DW-1:0] hd;
      hd = '0;
      @(negedge clock);
      if (mq.size() != 0) hd = mq[0];
      chk("count",    count,          mq.size());
      chk("rd_valid", rd_if.rd_valid, mq.size() != 0);
      chk("rd_data",  rd_if.rd_data,  hd);
      chk("dropped",  dropped,        mdrop);
      chk("busy",     busy,           mst == 1 || mst == 2);
      chk("done",     done,           mst == 3);
      model_step();
      @(posedge clock);
      #1;
   endtask

   task automatic dec(input bit dv, input logic [PC_W-1:0] pcv);
      decode_valid = dv;
      pc = pcv;
      opcode = 8'($urandom); a = 8'($urandom); x = 8'($urandom);
      y = 8'($urandom); p = 8'($urandom); sp = 8'($urandom);
   endtask

   task automatic do_arm(input bit ring, input logic [PC_W-1:0] tpc);
      ring_mode = ring; trig_pc = tpc; arm = 1'b1; dec(1'b0, '0);
      tick();
      arm = 1'b0;
   endtask

   function automatic logic [PC_W-1:0] head_pc();
      return rd_if.rd_data[PC_W+47 -: PC_W];
   endfunction

   function automatic logic [CYC_W-1:0] head_cyc();
      return rd_if.rd_data[DW-1 -: CYC_W];
   endfunction

   int ec [3] = '{2, 5, 9};

   initial begin
      reset = 1'b1; clock_en = 1'b1; arm = 1'b0; stop = 1'b0; ring_mode = 1'b0;
      trig_pc = '0; rd_if.rd_ready = 1'b0; dec(1'b0, '0);
      tick(); tick();
      reset = 1'b0;
      chk("rst_count", count, 0);
      chk("rst_valid", rd_if.rd_valid, 0);
      chk("rst_data",  rd_if.rd_data, 0);
      chk("rst_busy",  busy, 0);
      chk("rst_done",  done, 0);

      // basic capture: decodes at counter values 2, 5, 9
      do_arm(1'b0, 16'hC000);
      for (int i = 0; i < 10; i++) begin
         dec(i == 2 || i == 5 || i == 9, i == 2 ? 16'hC000 : (i == 5 ? 16'hC002 : 16'hC005));
         tick();
      end
      dec(1'b0, '0);
      chk("basic_count", count, 3);
      for (int k = 0; k < 3; k++) begin
         chk("basic_cyc", head_cyc(), ec[k]);
         rd_if.rd_ready = 1'b1;
         tick();
      end
      rd_if.rd_ready = 1'b0;
      chk("basic_empty_valid", rd_if.rd_valid, 0);
      chk("basic_empty_data",  rd_if.rd_data, 0);

      // stop mode fill
      do_arm(1'b0, 16'h0100);
      for (int i = 0; i < 6; i++) begin
         dec(1'b1, 16'h0100 + 16'(i));
         tick();
         if (i == 3) chk("fill_done", done, 1);
      end
      dec(1'b0, '0);
      chk("fill_count", count, 4);
      chk("fill_dropped", dropped, 0);
      for (int k = 0; k < 4; k++) begin
         chk("fill_pc", head_pc(), 16'h0100 + 16'(k));
         rd_if.rd_ready = 1'b1;
         tick();
      end
      rd_if.rd_ready = 1'b0;

      // ring overflow, then simultaneous pop and push while full
      do_arm(1'b1, 16'h0001);
      for (int i = 1; i <= 6; i++) begin
         dec(1'b1, 16'(i));
         tick();
      end
      chk("ring_count", count, 4);
      chk("ring_head", head_pc(), 3);
      chk("ring_dropped", dropped, 2);
      rd_if.rd_ready = 1'b1; dec(1'b1, 16'h0007);
      chk("pp_head_before", head_pc(), 3);
      tick();
      rd_if.rd_ready = 1'b0; dec(1'b0, '0);
      chk("pp_count", count, 4);
      chk("pp_dropped", dropped, 2);
      chk("pp_head_after", head_pc(), 4);
      stop = 1'b1; tick(); stop = 1'b0;
      chk("ring_stop_done", done, 1);

`ifdef TRACE_TRIG_EN
      do_arm(1'b0, 16'hC123);
      chk("trig_busy_armed", busy, 1);
      dec(1'b1, 16'hC000); tick();
      dec(1'b1, 16'hC123); tick();
      dec(1'b1, 16'hC125); tick();
      dec(1'b0, '0);
      chk("trig_count", count, 2);
      chk("trig_head", head_pc(), 16'hC123);
      do_arm(1'b0, 16'hDEAD);
      dec(1'b1, 16'hC000); tick();
      dec(1'b0, '0); stop = 1'b1; tick(); stop = 1'b0;
      chk("trig_stop_done", done, 1);
      chk("trig_stop_count", count, 0);
`endif

      // reset mid-capture, then re-arm from DONE with a full buffer
      do_arm(1'b0, 16'h0200);
      for (int i = 0; i < 3; i++) begin
         dec(1'b1, 16'h0200 + 16'(i));
         tick();
      end
      dec(1'b0, '0);
      chk("mid_count", count, 3);
      reset = 1'b1; tick(); reset = 1'b0;
      chk("mid_rst_count", count, 0);
      chk("mid_rst_valid", rd_if.rd_valid, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      do_arm(1'b0, 16'h0200);
      for (int i = 0; i < 4; i++) begin
         dec(1'b1, 16'h0200 + 16'(i));
         tick();
      end
      chk("rearm_full", count, 4);
      chk("rearm_done", done, 1);
      do_arm(1'b0, 16'h0200);
      chk("rearm_count", count, 0);
      dec(1'b1, 16'h0200); tick(); dec(1'b0, '0);
      chk("rearm_cyc", head_cyc(), 0);
      chk("rearm_count1", count, 1);

      // randomized traffic
      for (int i = 0; i < 4000; i++) begin
         reset          = ($urandom % 600) == 0;
         clock_en       = ($urandom % 8) != 0;
         arm            = ($urandom % 50) == 0;
         stop           = ($urandom % 70) == 0;
         ring_mode      = $urandom % 2;
         trig_pc        = 16'h0203;
         rd_if.rd_ready = ($urandom % 4) < ((i / 500) % 4);
         dec(($urandom % 3) != 0, 16'h0200 + 16'($urandom % 8));
         tick();
      end
      reset = 1'b0; arm = 1'b0; stop = 1'b0; dec(1'b0, '0);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
